// File: rtl/note_mixer.sv
// rtl/note_mixer.sv - scans note voices per sample tick, sums, scales and saturates into one mixed sample
module note_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 12,
  parameter int SHIFT      = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  input  logic [NUM_VOICES-1:0]          voice_valid,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic [NUM_VOICES-1:0]          agg_ack,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           mix_strobe,
  input  logic                           status_clr,
  output logic                           overrun,
  output logic [NUM_VOICES-1:0]          voice_missed
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SCAN, MIX} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [ACC_W-1:0]    acc;
  logic [WAIT_W-1:0]   wait_cnt;

  logic [SAMPLE_W-1:0]   cur_sample;
  logic                  cur_en;
  logic                  cur_valid;
  logic                  cur_timeout;
  logic                  advance;
  logic [NUM_VOICES-1:0] miss_set;
  logic [ACC_W-1:0]      shifted;
  logic [SAMPLE_W-1:0]   sat_mix;

  always_comb begin
    cur_sample = '0;
    cur_en     = 1'b0;
    cur_valid  = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_sample = voice_sample[i*SAMPLE_W +: SAMPLE_W];
        cur_en     = voice_enable[i];
        cur_valid  = voice_valid[i];
      end
    end
  end

  assign cur_timeout = cur_en && !cur_valid && (wait_cnt == WAIT_MAX);
  assign advance     = !cur_en || cur_valid || cur_timeout;

  always_comb begin
    agg_ack  = '0;
    miss_set = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (state == SCAN && idx == IDX_W'(i)) begin
        agg_ack[i]  = voice_enable[i] && voice_valid[i];
        miss_set[i] = cur_timeout;
      end
    end
  end

  // Anything left above SAMPLE_W after scaling means the mix clips at full scale.
  assign shifted = acc >> SHIFT;
  assign sat_mix = (|shifted[ACC_W-1:SAMPLE_W]) ? {SAMPLE_W{1'b1}} : shifted[SAMPLE_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      wait_cnt     <= '0;
      mix_out      <= '0;
      mix_strobe   <= 1'b0;
      overrun      <= 1'b0;
      voice_missed <= '0;
    end else begin
      mix_strobe   <= 1'b0;
      // A set event in the same cycle as status_clr keeps the bit high.
      overrun      <= (sample_tick && state != IDLE) || (overrun && !status_clr);
      voice_missed <= (voice_missed & ~{NUM_VOICES{status_clr}}) | miss_set;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state    <= SCAN;
            idx      <= '0;
            acc      <= '0;
            wait_cnt <= '0;
          end
        end
        SCAN: begin
          if (advance) begin
            if (cur_en && cur_valid) acc <= acc + ACC_W'(cur_sample);
            wait_cnt <= '0;
            if (idx == LAST_IDX) state <= MIX;
            else                 idx   <= idx + IDX_W'(1);
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        MIX: begin
          mix_out    <= sat_mix;
          mix_strobe <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/note_mixer.md
# note_mixer

Receiving end of the note voice sample interface. On each sample-rate tick, collects one 12-bit sample from each of `NUM_VOICES` note generators using a per-voice valid/ack handshake. Sums and scales the collected samples, then presents one saturated 12-bit mixed sample with a single-cycle strobe. Sits between the note voice array and the DAC/output serializer.

## Interface
- `NUM_VOICES`, 4, number of note voices scanned per frame (2..16)
- `SAMPLE_W`, 12, voice and output sample width, unsigned
- `SHIFT`, 1, right shift applied to the accumulated sum before saturation
- `TIMEOUT`, 15, cycles to wait for an enabled voice's valid before skipping it
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `sample_tick`  in  1  one-cycle strobe that starts a mix frame
- `voice_enable`  in  NUM_VOICES  per-voice enable; disabled voices contribute 0 and are never acked
- `voice_valid`  in  NUM_VOICES  voice i has a sample ready on its lane
- `voice_sample`  in  NUM_VOICES*SAMPLE_W  voice i sample on bits [i*SAMPLE_W +: SAMPLE_W]
- `agg_ack`  out  NUM_VOICES  one-cycle acknowledge to voice i; the sample is consumed in that cycle
- `mix_out`  out  SAMPLE_W  registered mixed sample, held between frames
- `mix_strobe`  out  1  one-cycle pulse when `mix_out` updates
- `status_clr`  in  1  clears the sticky status bits
- `overrun`  out  1  sticky: `sample_tick` arrived while a frame was in progress
- `voice_missed`  out  NUM_VOICES  sticky: voice i timed out in some frame

## Operation
- States: IDLE, SCAN, MIX.
- IDLE:
  - `sample_tick`=1 -> SCAN; `idx`=0, `acc`=0, `wait_cnt`=0.
- SCAN, voice `idx`:
  - `voice_enable[idx]`=0: advance, add nothing, no ack.
  - enabled and `voice_valid[idx]`=1: `acc += sample[idx]`, `agg_ack[idx]`=1 this cycle, advance.
  - enabled and not valid: `wait_cnt`++. On reaching `TIMEOUT`: set `voice_missed[idx]`, add nothing, advance.
  - Advance: `idx`++, `wait_cnt`=0. Advancing from `idx`=NUM_VOICES-1 -> MIX.
- `agg_ack` is combinational: `agg_ack[i]` = (SCAN && `idx`==i && `voice_enable[i]` && `voice_valid[i]`). At most one bit is high per cycle.
- MIX, one cycle:
  - `mix_out <= min(acc >> SHIFT, 2^SAMPLE_W-1)`.
  - `mix_strobe <= 1`.
  - -> IDLE.
- `acc` width: SAMPLE_W + clog2(NUM_VOICES); the sum never wraps.
- `sample_tick` while in SCAN or MIX: ignored, `overrun` set. The frame continues unaffected.
- `status_clr`: clears `overrun` and `voice_missed` on the next edge. A set event in the same cycle wins.
- Voices are scanned in ascending index order only. Voice samples are never buffered beyond the ack cycle.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE; `acc`, `idx`, `wait_cnt` = 0.
  - `mix_out`=0, `mix_strobe`=0, `agg_ack`=0, `overrun`=0, `voice_missed`=0.
- Reset mid-frame: frame aborted immediately, no strobe, no ack. `mix_out` returns to 0.
- Tick sampled at edge k -> SCAN, voice 0, during cycle k+1.
- Each voice occupies 1 cycle if valid or disabled, and at most TIMEOUT+1 cycles if it times out.
- All voices ready or disabled: SCAN cycles k+1..k+N, MIX cycle k+N+1, `mix_strobe` high during cycle k+N+2. State is IDLE in that cycle, so a tick there is accepted.
- Minimum tick spacing without overrun: N+2 cycles.
- `mix_strobe` is exactly one cycle wide. `mix_out` changes only on the edge that raises it.
- Voice contract: `voice_sample` is stable while `voice_valid` is high. The voice drops or refreshes valid in the cycle after `agg_ack`.

## Test plan
- N=4, SHIFT=1, all enabled and valid, samples 100/200/300/400, tick at k:
  - acks on voices 0..3 in cycles k+1..k+4.
  - `mix_out`=500, strobe in cycle k+6.
- All four samples 4095: sum 16380 >> 1 = 8190 -> `mix_out` saturates to 4095. `overrun`=0.
- `voice_enable`=4'b1011, samples 1000 each:
  - voice 2 never acked.
  - `mix_out`=1500, strobe at k+6.
- Voice 1 enabled but `voice_valid[1]` held 0, others 400:
  - voice 1 skipped after 15 wait cycles; `voice_missed`=4'b0010.
  - `mix_out`=600; strobe delayed by 15 cycles versus the all-valid case.
  - `status_clr` pulse returns `voice_missed` to 0.
- Second tick at k+3 during SCAN:
  - `overrun`=1, first frame completes normally, no second frame starts.
  - `rst` pulsed at k+2: no strobe, all outputs 0, next tick mixes normally.
